// File: rtl/freelist.sv
// Circular free list of physical register numbers feeding rename.
// Hands out up to two prds per cycle, reclaims committed old_prds, and rewinds on ROB rollback/walk.
module freelist #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_LREGS = 32,
  localparam int unsigned PW = $clog2(NUM_PREGS),
  localparam int unsigned FL_DEPTH = NUM_PREGS - NUM_LREGS,
  localparam int unsigned IW = $clog2(FL_DEPTH),
  localparam int unsigned CW = IW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rn2fl_instr0_alloc_req,
  input  logic          rn2fl_instr1_alloc_req,
  output logic [PW-1:0] fl2rn_instr0_prd,
  output logic [PW-1:0] fl2rn_instr1_prd,
  output logic          fl2rn_alloc_ready,
  input  logic          commit0_valid,
  input  logic          commit0_need_to_wb,
  input  logic [PW-1:0] commit0_old_prd,
  input  logic          commit1_valid,
  input  logic          commit1_need_to_wb,
  input  logic [PW-1:0] commit1_old_prd,
  input  logic [1:0]    rob_state,
  input  logic          walking_valid0,
  input  logic          walking_valid1,
  output logic [CW-1:0] fl_free_count,
  output logic          fl_overflow_err
);

  localparam logic [1:0] ROB_STATE_IDLE     = 2'd0;
  localparam logic [1:0] ROB_STATE_ROLLBACK = 2'd1;
  localparam logic [1:0] ROB_STATE_WALK     = 2'd2;
  localparam int unsigned OW = CW + 1;

  logic [PW-1:0] r_entry [FL_DEPTH];
  logic [CW-1:0] r_head;
  logic [CW-1:0] r_arch_head;
  logic [CW-1:0] r_tail;
  logic          r_overflow_err;

  logic          w_rel0;
  logic          w_rel1;
  logic [CW-1:0] w_rel_n;
  logic [CW-1:0] w_alloc_n;
  logic [CW-1:0] w_walk_n;
  logic [CW-1:0] w_adv_n;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_arch_head_next;
  logic [CW-1:0] w_head_next;
  logic [IW-1:0] w_hidx0;
  logic [IW-1:0] w_hidx1;
  logic [IW-1:0] w_widx0;
  logic [IW-1:0] w_widx1;
  logic          w_fire;
  logic          w_overflow;

  assign w_rel0   = commit0_valid && commit0_need_to_wb;
  assign w_rel1   = commit1_valid && commit1_need_to_wb;
  assign w_rel_n  = CW'(w_rel0) + CW'(w_rel1);
  assign w_count  = r_tail - r_head;

  assign fl2rn_alloc_ready = (w_count >= CW'(2)) && (rob_state == ROB_STATE_IDLE);
  assign w_fire            = fl2rn_alloc_ready;
  assign w_alloc_n = w_fire ? CW'(rn2fl_instr0_alloc_req) + CW'(rn2fl_instr1_alloc_req) : '0;
  assign w_walk_n  = CW'(walking_valid0) + CW'(walking_valid1);

  assign w_hidx0 = r_head[IW-1:0];
  assign w_hidx1 = w_hidx0 + IW'(1);
  assign w_widx0 = r_tail[IW-1:0];
  assign w_widx1 = w_widx0 + IW'(w_rel0);

  assign fl2rn_instr0_prd = r_entry[w_hidx0];
  assign fl2rn_instr1_prd = rn2fl_instr0_alloc_req ? r_entry[w_hidx1] : r_entry[w_hidx0];
  assign fl_free_count    = w_count;
  assign fl_overflow_err  = r_overflow_err;

  assign w_arch_head_next = r_arch_head + w_rel_n;

  always_comb begin
    w_head_next = r_head + w_alloc_n;
    w_adv_n     = w_alloc_n;
    if (rob_state == ROB_STATE_ROLLBACK) begin
      w_head_next = w_arch_head_next;
      w_adv_n     = '0;
    end else if (rob_state == ROB_STATE_WALK) begin
      w_head_next = r_head + w_walk_n;
      w_adv_n     = w_walk_n;
    end
  end

  // Rollback rewinds head to the committed pointer, so it cannot overfill the list.
  assign w_overflow = (rob_state != ROB_STATE_ROLLBACK) &&
                      ((OW'(w_count) + OW'(w_rel_n)) > (OW'(FL_DEPTH) + OW'(w_adv_n)));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(FL_DEPTH); i++) begin
        r_entry[i] <= PW'(NUM_LREGS + i);
      end
      r_head         <= '0;
      r_arch_head    <= '0;
      r_tail         <= CW'(FL_DEPTH);
      r_overflow_err <= 1'b0;
    end else begin
      if (w_rel0) r_entry[w_widx0] <= commit0_old_prd;
      if (w_rel1) r_entry[w_widx1] <= commit1_old_prd;
      r_tail      <= r_tail + w_rel_n;
      r_arch_head <= w_arch_head_next;
      r_head      <= w_head_next;
      if (w_overflow) r_overflow_err <= 1'b1;
    end
  end

endmodule
